branch_predictor_gshare_sa: RTL

Parametrised next-generation branch prediction unit for the 5-stage pipeline's fetch stage. It combines a 2-way set-associative BTB (LRU replacement) with a gshare direction predictor. The gshare predictor uses a PC-XOR-global-history index, N-bit saturating counters and a speculatively updated global history register (GHR) with mispredict recovery. Predictions are combinational on the fetch PC; training comes from the BRU at resolve time.

---
 rtl/branch_predictor_gshare_sa_if.sv | 33 +++
 rtl/branch_predictor_gshare_sa.sv | 134 +++++++++++++
 2 files changed

// File: rtl/branch_predictor_gshare_sa_if.sv
// Fetch-side prediction and BRU-side training signals of the gshare/BTB branch predictor.
// The pipeline drives through the master modport. The predictor uses the slave modport.
interface branch_predictor_gshare_sa_if #(
    parameter int XLEN  = 32,
    parameter int GHR_W = 8
);
    logic             fetch_valid;
    logic [XLEN-1:0]  PC_fetch;
    logic             prd_hit;
    logic             prd_taken;
    logic [XLEN-1:0]  prd_target;
    logic [GHR_W-1:0] prd_ghr;
    logic             br_update;
    logic [XLEN-1:0]  br_update_PC;
    logic             br_update_taken;
    logic [XLEN-1:0]  br_update_target;
    logic [GHR_W-1:0] br_update_ghr;
    logic             br_update_mispredict;

    modport master (
        output fetch_valid, PC_fetch,
        output br_update, br_update_PC, br_update_taken, br_update_target,
        output br_update_ghr, br_update_mispredict,
        input  prd_hit, prd_taken, prd_target, prd_ghr
    );

    modport slave (
        input  fetch_valid, PC_fetch,
        input  br_update, br_update_PC, br_update_taken, br_update_target,
        input  br_update_ghr, br_update_mispredict,
        output prd_hit, prd_taken, prd_target, prd_ghr
    );
endinterface

// File: rtl/branch_predictor_gshare_sa.sv
// Fetch-stage branch predictor: a 2-way LRU BTB supplies the targets, and a gshare PHT of saturating counters supplies the direction.
// The GHR is updated speculatively at fetch. A mispredict restores it from the snapshot that travelled with the branch.
module branch_predictor_gshare_sa #(
    parameter int XLEN        = 32,
    parameter int BTB_SETS    = 64,
    parameter int PHT_ENTRIES = 256,
    parameter int GHR_W       = 8,
    parameter int CNT_W       = 2
) (
    input logic                         clk_i,
    input logic                         rst_n,
    branch_predictor_gshare_sa_if.slave bp
);
    localparam int SET_W = $clog2(BTB_SETS);
    localparam int PHT_W = $clog2(PHT_ENTRIES);
    localparam int TAG_W = XLEN - 2 - SET_W;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // The lru bit of a set names the way that is the next victim.
    logic [BTB_SETS-1:0] valid_w0, valid_w1, lru;
    logic [TAG_W-1:0]    tag_w0 [BTB_SETS];
    logic [TAG_W-1:0]    tag_w1 [BTB_SETS];
    logic [XLEN-1:0]     tgt_w0 [BTB_SETS];
    logic [XLEN-1:0]     tgt_w1 [BTB_SETS];
    logic [CNT_W-1:0]    pht    [PHT_ENTRIES];
    logic [GHR_W-1:0]    ghr;

    logic [SET_W-1:0] f_set, u_set;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic [PHT_W-1:0] f_idx, u_idx;
    logic             f_hit0, f_hit1, f_hit, f_taken;
    logic [XLEN-1:0]  f_target;
    logic             u_hit0, u_hit1, u_way, btb_we;
    logic             unused_pc_bits;

    assign unused_pc_bits = ^{bp.PC_fetch[1:0], bp.br_update_PC[1:0]};

    assign f_set  = bp.PC_fetch[2+SET_W-1:2];
    assign f_tag  = bp.PC_fetch[XLEN-1:2+SET_W];
    assign f_idx  = bp.PC_fetch[2+PHT_W-1:2] ^ PHT_W'(ghr);
    assign f_hit0 = valid_w0[f_set] && (tag_w0[f_set] == f_tag);
    assign f_hit1 = valid_w1[f_set] && (tag_w1[f_set] == f_tag);
    assign f_hit  = f_hit0 | f_hit1;
    assign f_taken = bp.fetch_valid & f_hit & pht[f_idx][CNT_W-1];

    always_comb begin
        f_target = '0;
        if (f_hit0) begin
            f_target = tgt_w0[f_set];
        end else if (f_hit1) begin
            f_target = tgt_w1[f_set];
        end
    end

    assign bp.prd_hit    = f_hit;
    assign bp.prd_taken  = f_taken;
    assign bp.prd_target = f_target;
    assign bp.prd_ghr    = ghr;

    assign u_set  = bp.br_update_PC[2+SET_W-1:2];
    assign u_tag  = bp.br_update_PC[XLEN-1:2+SET_W];
    assign u_idx  = bp.br_update_PC[2+PHT_W-1:2] ^ PHT_W'(bp.br_update_ghr);
    assign u_hit0 = valid_w0[u_set] && (tag_w0[u_set] == u_tag);
    assign u_hit1 = valid_w1[u_set] && (tag_w1[u_set] == u_tag);
    assign btb_we = bp.br_update & bp.br_update_taken;

    // A hit way is checked first. This keeps the same tag out of both ways of a set.
    always_comb begin
        u_way = 1'b0;
        if (u_hit0) begin
            u_way = 1'b0;
        end else if (u_hit1) begin
            u_way = 1'b1;
        end else if (!valid_w0[u_set]) begin
            u_way = 1'b0;
        end else if (!valid_w1[u_set]) begin
            u_way = 1'b1;
        end else begin
            u_way = lru[u_set];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            valid_w0 <= '0;
            valid_w1 <= '0;
            lru      <= '0;
            for (int s = 0; s < BTB_SETS; s++) begin
                tag_w0[s] <= '0;
                tag_w1[s] <= '0;
                tgt_w0[s] <= '0;
                tgt_w1[s] <= '0;
            end
        end else if (btb_we) begin
            if (u_way == 1'b0) begin
                valid_w0[u_set] <= 1'b1;
                tag_w0[u_set]   <= u_tag;
                tgt_w0[u_set]   <= bp.br_update_target;
                lru[u_set]      <= 1'b1;
            end else begin
                valid_w1[u_set] <= 1'b1;
                tag_w1[u_set]   <= u_tag;
                tgt_w1[u_set]   <= bp.br_update_target;
                lru[u_set]      <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= CNT_INIT;
            end
        end else if (bp.br_update) begin
            if (bp.br_update_taken && (pht[u_idx] != CNT_MAX)) begin
                pht[u_idx] <= pht[u_idx] + CNT_W'(1);
            end else if (!bp.br_update_taken && (pht[u_idx] != '0)) begin
                pht[u_idx] <= pht[u_idx] - CNT_W'(1);
            end
        end
    end

    // The width cast drops the oldest history bit when the new outcome is shifted in.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (bp.br_update && bp.br_update_mispredict) begin
            ghr <= GHR_W'({bp.br_update_ghr, bp.br_update_taken});
        end else if (bp.fetch_valid && f_hit) begin
            ghr <= GHR_W'({ghr, f_taken});
        end
    end
endmodule
